dac_stream_seq: RTL and testbench
=================================

Name: dac_stream_seq

Overview:
Parametrised sample sequencer that feeds a busy-handshake serial DAC writer, such as the team's MCP4725 I2C driver. It generates N_CH sample streams (ramp, triangle, external or hold) at a programmable sample rate. Each frame issues the channels in round-robin order, one at a time. All handshakes are synchronous to clk; the DAC driver's busy is never used as a clock, and its completion is detected as a falling edge sampled on clk.

Parameters:
DATA_W, 12, sample width in bits.
N_CH, 2, number of channels per frame (1..8).
CH_W, 3, width of channel index (ceil log2 of N_CH, minimum 1).
DIV_W, 16, width of sample-period divider.
TIMEOUT, 1023, maximum cycles from dac_start to dac_busy rising.

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  run request.
mode  in  2  0=RAMP, 1=TRIANGLE, 2=EXT, 3=HOLD.
step  in  DATA_W  increment per frame for RAMP and TRIANGLE.
period  in  DIV_W  sample period in clk cycles; 0 is treated as 1.
ext_data  in  N_CH*DATA_W  external samples; channel k occupies bits [k*DATA_W +: DATA_W].
clr_err  in  1  clears the sticky overrun and timeout flags.
dac_busy  in  1  busy signal from the DAC driver.
dac_start  out  1  one-cycle transfer request.
dac_data  out  DATA_W  sample for the current transfer; held stable from dac_start until busy falls.
dac_ch  out  CH_W  channel index for the current transfer.
frame_done  out  1  one-cycle pulse after the last channel of a frame completes.
overrun  out  1  sticky: a tick occurred while a frame was in flight.
timeout  out  1  sticky: busy did not rise within TIMEOUT cycles.

Behaviour:
- Reset values: dac_start=0, dac_data=0, dac_ch=0, frame_done=0, overrun=0, timeout=0. Divider=0. Accumulator k=k*(2^DATA_W/N_CH), i.e. phase-spread. All directions=up. FSM=IDLE. Reset asserted mid-transfer aborts the transfer immediately.
- Divider: free-runs while enable=1. Asserts tick when count==max(period,1)-1, then wraps to 0. Cleared while enable=0.
- busy_q: registered dac_busy. busy_fall = busy_q & ~dac_busy.
- FSM states:
  - IDLE: waits for enable=1, then goes to WAIT_TICK.
  - WAIT_TICK: on tick, ch=0, goes to ISSUE. If enable=0, goes to IDLE.
  - ISSUE: for one cycle, dac_start=1, dac_data=sample[ch], dac_ch=ch, and the timeout counter is cleared. Goes to WAIT_BUSY.
  - WAIT_BUSY: on dac_busy=1, goes to WAIT_DONE. If the counter reaches TIMEOUT first: timeout=1, the frame is abandoned without a frame_done pulse or accumulator update, and the FSM goes to WAIT_TICK.
  - WAIT_DONE: on busy_fall, if ch<N_CH-1 then ch++ and go to ISSUE. Otherwise go to UPDATE.
  - UPDATE: for one cycle, frame_done=1 and every accumulator advances. Goes to WAIT_TICK, or to IDLE if enable=0.
- Latency: dac_start is asserted 1 cycle after the tick.
- Deassert during a frame: enable=0 mid-frame completes the whole frame, then goes to IDLE.
- Overrun rule: a tick in any state other than WAIT_TICK sets overrun and is dropped (not queued).
- Simultaneous events: if clr_err and a set event occur in the same cycle, the set wins.
- Accumulator update in UPDATE (DATA_W-bit arithmetic, MAX=2^DATA_W-1):
  - RAMP: s=s+step modulo 2^DATA_W; wraps silently.
  - TRIANGLE, up: if s>MAX-step then s=MAX and dir=down, else s+=step.
  - TRIANGLE, down: if s<step then s=0 and dir=up, else s-=step.
  - EXT: s=ext_data channel slice.
  - HOLD: no change.
  - step=0 holds s in every generating mode.
- Mode change: takes effect at the next UPDATE; existing accumulator values are kept.

Decomposition:
- Shared package dac_pkg: mode encoding constants MODE_RAMP/TRI/EXT/HOLD, FSM state encoding, and the default DATA_W.
- One natural sub-module, dac_wave_acc: a single-channel accumulator with mode, step, direction and load. It is instantiated N_CH times with an initial-value parameter.

Test Plan:
- Reset and defaults: reset, then enable=1, mode=RAMP, step=1, period=100, with a driver model giving busy 20 cycles after start -> dac_start 1 cycle after each tick; ch0 data 0, ch1 data 2048 at frame 0; ch0=1, ch1=2049 at frame 1.
- Ramp wrap: DATA_W=12, step=4000, ch0 starting at 0 -> ch0 samples 0, 4000, 3904.
- Triangle clamp: step=1500 -> ch0 samples 0, 1500, 3000, 4095, 2595, 1095, 0, 1500.
- Overrun: period=10 with a 40-cycle busy -> overrun=1 and frame_done period ≥ 40 cycles; clr_err=1 for one cycle with a slow driver -> overrun clears and re-sets on the next dropped tick.
- Timeout: driver never raises busy with TIMEOUT=1023 -> timeout=1 exactly 1023 cycles after dac_start, no frame_done pulse, and the next tick reissues from ch0.
- Stop and reset: enable=0 mid-frame -> remaining channels are still sent, followed by frame_done and then IDLE with no further dac_start. rst_n low during WAIT_DONE -> all outputs go to 0 immediately.

Source files
------------

// File: rtl/dac_pkg.sv
// dac_pkg: shared encodings for the DAC sample sequencer.
// Mode codes, FSM states and the default sample width.
package dac_pkg;

  localparam int DAC_DATA_W = 12;

  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_TRI  = 2'd1;
  localparam logic [1:0] MODE_EXT  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_UPDATE
  } state_t;

endpackage

// File: rtl/dac_stream_seq_if.sv
// dac_stream_seq_if: start/busy handshake toward a serial DAC writer.
// master = sequencer side, slave = DAC driver side.
interface dac_stream_seq_if
  import dac_pkg::*;
#(
  parameter int DATA_W = DAC_DATA_W,
  parameter int CH_W   = 3
);

  logic              dac_start;
  logic [DATA_W-1:0] dac_data;
  logic [CH_W-1:0]   dac_ch;
  logic              dac_busy;

  modport master (
    output dac_start,
    output dac_data,
    output dac_ch,
    input  dac_busy
  );

  modport slave (
    input  dac_start,
    input  dac_data,
    input  dac_ch,
    output dac_busy
  );

endinterface

// File: rtl/dac_wave_acc.sv
// dac_wave_acc: one channel's sample accumulator.
// Advances once per frame by ramp, triangle, external load or hold.
module dac_wave_acc
  import dac_pkg::*;
#(
  parameter int                DATA_W = DAC_DATA_W,
  parameter logic [DATA_W-1:0] INIT   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_upd,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_step,
  input  logic [DATA_W-1:0] i_ext,
  output logic [DATA_W-1:0] o_val
);

  localparam logic [DATA_W-1:0] MAX = '1;

  logic [DATA_W-1:0] r_val;
  logic              r_down;

  assign o_val = r_val;

  // frame update; triangle clamps at the rails and flips direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val  <= INIT;
      r_down <= 1'b0;
    end else if (i_upd) begin
      unique case (i_mode)
        MODE_RAMP: r_val <= r_val + i_step;
        MODE_TRI: begin
          if (!r_down) begin
            if (r_val > MAX - i_step) begin
              r_val  <= MAX;
              r_down <= 1'b1;
            end else begin
              r_val <= r_val + i_step;
            end
          end else begin
            if (r_val < i_step) begin
              r_val  <= '0;
              r_down <= 1'b0;
            end else begin
              r_val <= r_val - i_step;
            end
          end
        end
        MODE_EXT:  r_val <= i_ext;
        default:   r_val <= r_val;
      endcase
    end
  end

endmodule

// File: rtl/dac_stream_seq.sv
// dac_stream_seq: frame sequencer feeding a busy-handshake DAC writer.
// Issues N_CH channels round-robin once per divider tick.
module dac_stream_seq
  import dac_pkg::*;
#(
  parameter int DATA_W  = DAC_DATA_W,
  parameter int N_CH    = 2,
  parameter int CH_W    = 3,
  parameter int DIV_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [DATA_W-1:0]      step,
  input  logic [DIV_W-1:0]       period,
  input  logic [N_CH*DATA_W-1:0] ext_data,
  input  logic                   clr_err,
  dac_stream_seq_if.master       dac,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  // counter starts the cycle after dac_start, so the flag
  // lands exactly TIMEOUT cycles after the request
  localparam logic [TO_W-1:0] TO_HIT = TO_W'(TIMEOUT - 2);

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic                r_busy_q;
  logic [CH_W-1:0]     r_ch;
  logic                r_start;
  logic [DATA_W-1:0]   r_data;
  logic [CH_W-1:0]     r_chout;
  logic                r_fdone;
  logic                r_ovr;
  logic                r_to;
  logic [TO_W-1:0]     r_tcnt;

  logic [DIV_W-1:0]       w_pm1;
  logic                   w_tick;
  logic                   w_busy_fall;
  logic                   w_to_set;
  logic                   w_ovr_set;
  logic                   w_upd;
  logic [CH_W-1:0]        w_nxt_ch;
  logic [DATA_W-1:0]      w_nxt_smp;
  logic [N_CH*DATA_W-1:0] w_acc;

  assign w_pm1 = (period == '0) ? '0
               : period - DIV_W'(1);
  assign w_tick = enable & (r_div >= w_pm1);
  assign w_busy_fall = r_busy_q & ~dac.dac_busy;
  assign w_upd = (r_state == S_UPDATE);
  assign w_to_set = (r_state == S_WAIT_BUSY)
                  & ~dac.dac_busy
                  & (r_tcnt == TO_HIT);
  assign w_ovr_set = w_tick
                   & (r_state != S_WAIT_TICK);
  assign w_nxt_ch = (r_state == S_WAIT_TICK) ? '0
                  : r_ch + CH_W'(1);

  assign dac.dac_start = r_start;
  assign dac.dac_data  = r_data;
  assign dac.dac_ch    = r_chout;
  assign frame_done    = r_fdone;
  assign overrun       = r_ovr;
  assign timeout       = r_to;

  // channel accumulators, phase-spread across the code range
  for (genvar k = 0; k < N_CH; k++) begin : g_acc
    dac_wave_acc #(
      .DATA_W (DATA_W),
      .INIT   (DATA_W'(k * ((2 ** DATA_W) / N_CH)))
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_upd  (w_upd),
      .i_mode (mode),
      .i_step (step),
      .i_ext  (ext_data[k*DATA_W +: DATA_W]),
      .o_val  (w_acc[k*DATA_W +: DATA_W])
    );
  end

  // select the sample for the channel about to be issued
  always_comb begin
    w_nxt_smp = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_nxt_ch == CH_W'(k))
        w_nxt_smp = w_acc[k*DATA_W +: DATA_W];
    end
  end

  // sample-period divider, free-running while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_div <= '0;
    else if (!enable) r_div <= '0;
    else if (w_tick)  r_div <= '0;
    else              r_div <= r_div + DIV_W'(1);
  end

  // busy history for falling-edge detection on clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy_q <= 1'b0;
    else        r_busy_q <= dac.dac_busy;
  end

  // sticky overrun; a new set beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovr <= 1'b0;
    else        r_ovr <= w_ovr_set | (r_ovr & ~clr_err);
  end

  // frame FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_start <= 1'b0;
      r_data  <= '0;
      r_chout <= '0;
      r_fdone <= 1'b0;
      r_tcnt  <= '0;
      r_to    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_fdone <= 1'b0;
      r_to    <= w_to_set | (r_to & ~clr_err);
      unique case (r_state)
        S_IDLE: begin
          if (enable) r_state <= S_WAIT_TICK;
        end
        S_WAIT_TICK: begin
          if (w_tick) begin
            r_ch    <= w_nxt_ch;
            r_chout <= w_nxt_ch;
            r_data  <= w_nxt_smp;
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end else if (!enable) begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_tcnt  <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (dac.dac_busy) r_state <= S_WAIT_DONE;
          else if (w_to_set) r_state <= S_WAIT_TICK;
          else r_tcnt <= r_tcnt + TO_W'(1);
        end
        S_WAIT_DONE: begin
          if (w_busy_fall) begin
            if (r_ch != LAST_CH) begin
              r_ch    <= w_nxt_ch;
              r_chout <= w_nxt_ch;
              r_data  <= w_nxt_smp;
              r_start <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_fdone <= 1'b1;
              r_state <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          r_state <= enable ? S_WAIT_TICK : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_stream_seq.sv
// tb_dac_stream_seq: directed scenarios for dac_stream_seq.
// A busy-handshake driver model answers every dac_start.
module tb_dac_stream_seq;
  import dac_pkg::*;

  localparam int DW  = 12;
  localparam int NC  = 2;
  localparam int CW  = 3;
  localparam int DVW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = MODE_RAMP;
  logic [DW-1:0] step = 12'd1;
  logic [DVW-1:0] period = 16'd100;
  logic [NC*DW-1:0] ext_data = '0;
  logic          clr_err = 1'b0;
  logic          frame_done;
  logic          overrun;
  logic          timeout;

  dac_stream_seq_if #(.DATA_W(DW), .CH_W(CW)) dif();

  dac_stream_seq #(
    .DATA_W(DW), .N_CH(NC), .CH_W(CW),
    .DIV_W(DVW), .TIMEOUT(1023)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .step       (step),
    .period     (period),
    .ext_data   (ext_data),
    .clr_err    (clr_err),
    .dac        (dif),
    .frame_done (frame_done),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int st_cyc[$];
  int st_ch[$];
  int st_dat[$];
  int fd_cyc[$];
  int drv_lat = 20;
  int drv_len = 5;
  bit drv_never = 1'b0;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // log every request and frame pulse with its cycle number
  initial forever begin
    @(negedge clk);
    if (dif.dac_start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_ch.push_back(int'(dif.dac_ch));
      st_dat.push_back(int'(dif.dac_data));
    end
    if (frame_done === 1'b1) fd_cyc.push_back(cyc);
  end

  // DAC driver model: busy drv_lat cycles after start, drv_len long
  initial begin
    dif.dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (dif.dac_start === 1'b1 && !drv_never) begin
        repeat (drv_lat) @(negedge clk);
        dif.dac_busy = 1'b1;
        repeat (drv_len) @(negedge clk);
        dif.dac_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    clr_err = 1'b0;
    rst_n = 1'b0;
    repeat (60) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    st_cyc.delete();
    st_ch.delete();
    st_dat.delete();
    fd_cyc.delete();
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget && st_cyc.size() < n; i++)
      @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ch_start(input int ch, input int budget,
                               output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dif.dac_start === 1'b1 && int'(dif.dac_ch) == ch) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    do_reset();
    got = {dif.dac_start, frame_done, overrun, timeout,
           |dif.dac_data, |dif.dac_ch};
    n_cmp++;
    if (got !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b expected 000000", got);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (st_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL idle_no_start: got %0d starts expected 0",
               st_cyc.size());
    end
  endtask

  task automatic test_defaults();
    int e;
    int exp_d[4] = '{0, 2048, 1, 2049};
    int exp_c[4] = '{0, 1, 0, 1};
    int exp_t[3] = '{100, 126, 200};
    do_reset();
    mode = MODE_RAMP; step = 12'd1; period = 16'd100;
    drv_lat = 20; drv_len = 5;
    @(negedge clk);
    enable = 1'b1;
    e = cyc;
    wait_starts(4, 400);
    n_cmp++;
    if (st_cyc.size() < 4 || fd_cyc.size() < 1) begin
      n_bad++;
      $display("FAIL dflt_count: got %0d starts expected 4",
               st_cyc.size());
      return;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (st_dat[i] != exp_d[i] || st_ch[i] != exp_c[i]) begin
        n_bad++;
        $display("FAIL dflt_smp%0d: got ch%0d/%0d expected ch%0d/%0d",
                 i, st_ch[i], st_dat[i], exp_c[i], exp_d[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (st_cyc[i] - e != exp_t[i]) begin
        n_bad++;
        $display("FAIL dflt_time%0d: got %0d expected %0d",
                 i, st_cyc[i] - e, exp_t[i]);
      end
    end
    n_cmp++;
    if (fd_cyc[0] - e != 152) begin
      n_bad++;
      $display("FAIL dflt_fdone: got %0d expected 152",
               fd_cyc[0] - e);
    end
  endtask

  task automatic test_ramp_wrap();
    int exp0[3] = '{0, 4000, 3904};
    int exp1[3] = '{2048, 1952, 1856};
    do_reset();
    mode = MODE_RAMP; step = 12'd4000; period = 16'd100;
    @(negedge clk);
    enable = 1'b1;
    wait_starts(6, 700);
    n_cmp++;
    if (st_cyc.size() < 6) begin
      n_bad++;
      $display("FAIL ramp_count: got %0d starts expected 6",
               st_cyc.size());
      return;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (st_dat[2*i] != exp0[i] || st_dat[2*i+1] != exp1[i]) begin
        n_bad++;
        $display("FAIL ramp_f%0d: got %0d,%0d expected %0d,%0d", i,
                 st_dat[2*i], st_dat[2*i+1], exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic test_triangle();
    int exp0[8] = '{0, 1500, 3000, 4095, 2595, 1095, 0, 1500};
    int exp1[8] = '{2048, 3548, 4095, 2595, 1095, 0, 1500, 3000};
    do_reset();
    mode = MODE_TRI; step = 12'd1500; period = 16'd100;
    @(negedge clk);
    enable = 1'b1;
    wait_starts(16, 1800);
    n_cmp++;
    if (st_cyc.size() < 16) begin
      n_bad++;
      $display("FAIL tri_count: got %0d starts expected 16",
               st_cyc.size());
      return;
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (st_dat[2*i] != exp0[i] || st_dat[2*i+1] != exp1[i]) begin
        n_bad++;
        $display("FAIL tri_f%0d: got %0d,%0d expected %0d,%0d", i,
                 st_dat[2*i], st_dat[2*i+1], exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic test_ext_hold();
    int exp_d[6] = '{0, 2048, 'h123, 'hABC, 'h123, 'hABC};
    do_reset();
    mode = MODE_EXT; period = 16'd100;
    ext_data = {12'hABC, 12'h123};
    @(negedge clk);
    enable = 1'b1;
    wait_starts(3, 400);
    mode = MODE_HOLD;
    ext_data = {12'h555, 12'h777};
    wait_starts(6, 400);
    n_cmp++;
    if (st_cyc.size() < 6) begin
      n_bad++;
      $display("FAIL ext_count: got %0d starts expected 6",
               st_cyc.size());
      return;
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (st_dat[i] != exp_d[i]) begin
        n_bad++;
        $display("FAIL ext_smp%0d: got %0h expected %0h",
                 i, st_dat[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    mode = MODE_RAMP; step = 12'd1; period = 16'd10;
    drv_lat = 2; drv_len = 40;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 600 && fd_cyc.size() < 2; i++)
      @(negedge clk);
    n_cmp++;
    if (fd_cyc.size() < 2) begin
      n_bad++;
      $display("FAIL ovr_frames: got %0d expected 2", fd_cyc.size());
      return;
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_set: got %b expected 1", overrun);
    end
    n_cmp++;
    if (fd_cyc[1] - fd_cyc[0] < 40) begin
      n_bad++;
      $display("FAIL ovr_spacing: got %0d expected >=40",
               fd_cyc[1] - fd_cyc[0]);
    end
    wait_ch_start(0, 300, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL ovr_start: got none expected ch0 start");
      return;
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_clr: got %b expected 0", overrun);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_hold0: got %b expected 0", overrun);
    end
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_reset: got %b expected 1", overrun);
    end
    drv_lat = 20; drv_len = 5;
  endtask

  task automatic test_timeout();
    bit ok;
    int s;
    do_reset();
    mode = MODE_RAMP; step = 12'd1; period = 16'd1500;
    drv_never = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    wait_ch_start(0, 2000, ok);
    s = cyc;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL to_start: got none expected ch0 start");
      drv_never = 1'b0;
      return;
    end
    repeat (1022) @(negedge clk);
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL to_early: got %b expected 0", timeout);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL to_set: got %b expected 1", timeout);
    end
    wait_ch_start(0, 600, ok);
    n_cmp++;
    if (!ok || cyc - s != 1500 || dif.dac_data !== 12'd0) begin
      n_bad++;
      $display("FAIL to_reissue: got +%0d data %0d expected +1500 0",
               cyc - s, dif.dac_data);
    end
    n_cmp++;
    if (fd_cyc.size() != 0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL to_nofd: got %0d fd ovr %b expected 0 0",
               fd_cyc.size(), overrun);
    end
    drv_never = 1'b0;
  endtask

  task automatic test_stop();
    bit ok;
    int s;
    do_reset();
    mode = MODE_RAMP; step = 12'd1; period = 16'd100;
    @(negedge clk);
    enable = 1'b1;
    wait_ch_start(0, 300, ok);
    s = cyc;
    enable = 1'b0;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (!ok || st_cyc.size() != 2) begin
      n_bad++;
      $display("FAIL stop_starts: got %0d expected 2",
               st_cyc.size());
      return;
    end
    n_cmp++;
    if (st_ch[1] != 1 || st_cyc[1] - s != 26) begin
      n_bad++;
      $display("FAIL stop_ch1: got ch%0d +%0d expected ch1 +26",
               st_ch[1], st_cyc[1] - s);
    end
    n_cmp++;
    if (fd_cyc.size() != 1) begin
      n_bad++;
      $display("FAIL stop_fd: got %0d expected 1", fd_cyc.size());
      return;
    end
    n_cmp++;
    if (fd_cyc[0] - s != 52) begin
      n_bad++;
      $display("FAIL stop_fdtime: got +%0d expected +52",
               fd_cyc[0] - s);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [3:0] got;
    do_reset();
    mode = MODE_RAMP; step = 12'd1; period = 16'd100;
    @(negedge clk);
    enable = 1'b1;
    wait_ch_start(1, 300, ok);
    for (int i = 0; i < 40 && dif.dac_busy !== 1'b1; i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!ok || dif.dac_ch !== 3'd1 || dif.dac_data !== 12'd2048) begin
      n_bad++;
      $display("FAIL mid_pre: got ch%0d/%0d expected ch1/2048",
               dif.dac_ch, dif.dac_data);
    end
    rst_n = 1'b0;
    #1;
    got = {dif.dac_start, frame_done, |dif.dac_data, |dif.dac_ch};
    n_cmp++;
    if (got !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got %b expected 0000", got);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_ramp_wrap();
    test_triangle();
    test_ext_hold();
    test_overrun();
    test_timeout();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
